// File: rtl/threshold_pkg.sv
// Shared types and helpers for the multi-channel time-since-threshold tracker.
package threshold_pkg;

   // Per-channel hysteresis state.
   typedef enum logic {
      ARMED     = 1'b0,
      TRIGGERED = 1'b1
   } trk_state_e;

   // Saturating increment: returns max once count has reached it.
   function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max);
      logic [31:0] res;
      if (count >= max) begin
         res = max;
      end else begin
         res = count + 32'd1;
      end
      return res;
   endfunction

   // One step of an arg-min reduction: 1 when the candidate beats the
   // current best. Strict compare so ties keep the earlier (lower) index.
   function automatic logic argmin(input logic [31:0] best_val, input logic [31:0] cand_val);
      logic take;
      if (cand_val < best_val) begin
         take = 1'b1;
      end else begin
         take = 1'b0;
      end
      return take;
   endfunction

endpackage

// File: rtl/threshold_channel.sv
// One tracker lane: saturating time-since-trigger count plus ARMED/TRIGGERED flag.
module threshold_channel
   import threshold_pkg::*;
#(
   parameter int MAX_TIME = 1000,
   parameter int TW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          hit,
   input  logic          rel,
   input  logic          tu_en,
   output logic [TW-1:0] count,
   output logic          active
);

   localparam logic [TW-1:0] MAX_TW = TW'(MAX_TIME);

   trk_state_e    state_r, state_nxt_s;
   logic [TW-1:0] count_r, count_nxt_s;

   // Next state: clear beats trigger, trigger beats increment; timeout re-arms.
   always_comb begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      if (clr) begin
         count_nxt_s = MAX_TW;
         state_nxt_s = ARMED;
      end else if (hit) begin
         count_nxt_s = '0;
         state_nxt_s = TRIGGERED;
      end else begin
         if (tu_en) begin
            count_nxt_s = TW'(sat_inc(32'(count_r), 32'(MAX_TIME)));
         end else begin
            count_nxt_s = count_r;
         end
         case (state_r)
            TRIGGERED: begin
               if (rel || (count_nxt_s == MAX_TW)) begin
                  state_nxt_s = ARMED;
               end else begin
                  state_nxt_s = TRIGGERED;
               end
            end
            ARMED:   state_nxt_s = ARMED;
            default: state_nxt_s = ARMED;
         endcase
      end
   end

   // State and count registers; reset starts the lane saturated and armed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ARMED;
         count_r <= MAX_TW;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
      end
   end

   assign count  = count_r;
   assign active = (state_r == TRIGGERED);

endmodule

// File: rtl/multi_threshold_tracker.sv
// Multi-channel time-since-threshold tracker: channel decode, per-lane trackers,
// registered most-recent-channel selection and hit/error pulses.
module multi_threshold_tracker
   import threshold_pkg::*;
#(
   parameter int  DW       = 16,
   parameter int  NCH      = 4,
   parameter int  MAX_TIME = 1000,
   localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int TW       = $clog2(MAX_TIME + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic [NCH-1:0]    clr_ch_i,
   input  logic              tu_en,
   input  logic [DW-1:0]     thr_hi_i,
   input  logic [DW-1:0]     thr_lo_i,
   input  logic [DW-1:0]     signal_i,
   input  logic [CW-1:0]     ch_i,
   input  logic              valid_i,
   output logic [NCH*TW-1:0] tu_since_o,
   output logic [NCH-1:0]    active_o,
   output logic              hit_o,
   output logic [CW-1:0]     hit_ch_o,
   output logic [CW-1:0]     recent_ch_o,
   output logic              recent_valid_o,
   output logic              err_o
);

   logic              in_range_s;
   logic              sel_s;
   logic [NCH-1:0]    hit_s, rel_s, clr_s;
   logic [TW-1:0]     count_s [NCH];
   logic [CW-1:0]     best_idx_s;
   logic [TW-1:0]     best_val_s;
   logic              hit_r, err_r, recent_valid_r;
   logic [CW-1:0]     hit_ch_r, recent_ch_r;

   // Decode the tagged sample into per-lane trigger/release/clear strobes.
   always_comb begin
      in_range_s = (32'(ch_i) < 32'(NCH));
      sel_s      = valid_i && in_range_s;
      hit_s      = '0;
      rel_s      = '0;
      clr_s      = '0;
      for (int k = 0; k < NCH; k++) begin
         clr_s[k] = clr_i || clr_ch_i[k];
         // A cleared lane must not report a hit it never took.
         hit_s[k] = sel_s && (32'(ch_i) == 32'(k)) && (signal_i > thr_hi_i) && !clr_s[k];
         rel_s[k] = sel_s && (32'(ch_i) == 32'(k)) && (signal_i < thr_lo_i);
      end
   end

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         threshold_channel #(
            .MAX_TIME (MAX_TIME),
            .TW       (TW)
         ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr_s[g]),
            .hit    (hit_s[g]),
            .rel    (rel_s[g]),
            .tu_en  (tu_en),
            .count  (count_s[g]),
            .active (active_o[g])
         );
         assign tu_since_o[g*TW +: TW] = count_s[g];
      end
   endgenerate

   // Linear arg-min over the registered lane counts, lowest index wins ties.
   always_comb begin
      best_idx_s = '0;
      best_val_s = count_s[0];
      for (int k = 1; k < NCH; k++) begin
         if (argmin(32'(best_val_s), 32'(count_s[k]))) begin
            best_idx_s = CW'(k);
            best_val_s = count_s[k];
         end else begin
            best_idx_s = best_idx_s;
            best_val_s = best_val_s;
         end
      end
   end

   // Output registers: single-cycle hit/err pulses and the recent-channel result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_r          <= 1'b0;
         hit_ch_r       <= '0;
         err_r          <= 1'b0;
         recent_ch_r    <= '0;
         recent_valid_r <= 1'b0;
      end else begin
         hit_r          <= |hit_s;
         hit_ch_r       <= (|hit_s) ? ch_i : hit_ch_r;
         err_r          <= valid_i && !in_range_s;
         recent_ch_r    <= best_idx_s;
         recent_valid_r <= (32'(best_val_s) < 32'(MAX_TIME));
      end
   end

   assign hit_o          = hit_r;
   assign hit_ch_o       = hit_ch_r;
   assign err_o          = err_r;
   assign recent_ch_o    = recent_ch_r;
   assign recent_valid_o = recent_valid_r;

endmodule

// File: tb/tb_multi_threshold_tracker.sv
// Directed self-checking bench for multi_threshold_tracker (NCH=4 and NCH=3 instances).
module tb_multi_threshold_tracker;

   logic        clk = 1'b0;
   logic        rst_n, clr_i, tu_en, valid_i;
   logic [3:0]  clr_ch_i;
   logic [15:0] thr_hi_i, thr_lo_i, signal_i;
   logic [1:0]  ch_i;

   logic [39:0] tu_since_o;
   logic [3:0]  active_o;
   logic        hit_o, recent_valid_o, err_o;
   logic [1:0]  hit_ch_o, recent_ch_o;

   logic [29:0] b_tu_since_o;
   logic [2:0]  b_active_o;
   logic        b_hit_o, b_recent_valid_o, b_err_o;
   logic [1:0]  b_hit_ch_o, b_recent_ch_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multi_threshold_tracker #(.DW(16), .NCH(4), .MAX_TIME(1000)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .clr_ch_i(clr_ch_i), .tu_en(tu_en),
      .thr_hi_i(thr_hi_i), .thr_lo_i(thr_lo_i), .signal_i(signal_i), .ch_i(ch_i),
      .valid_i(valid_i), .tu_since_o(tu_since_o), .active_o(active_o), .hit_o(hit_o),
      .hit_ch_o(hit_ch_o), .recent_ch_o(recent_ch_o), .recent_valid_o(recent_valid_o),
      .err_o(err_o)
   );

   multi_threshold_tracker #(.DW(16), .NCH(3), .MAX_TIME(1000)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .clr_ch_i(clr_ch_i[2:0]), .tu_en(tu_en),
      .thr_hi_i(thr_hi_i), .thr_lo_i(thr_lo_i), .signal_i(signal_i), .ch_i(ch_i),
      .valid_i(valid_i), .tu_since_o(b_tu_since_o), .active_o(b_active_o), .hit_o(b_hit_o),
      .hit_ch_o(b_hit_ch_o), .recent_ch_o(b_recent_ch_o), .recent_valid_o(b_recent_valid_o),
      .err_o(b_err_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [1:0] ch, input logic [15:0] val);
      valid_i  = 1'b1;
      ch_i     = ch;
      signal_i = val;
   endtask

   function automatic logic [39:0] tus(input int c3, input int c2, input int c1, input int c0);
      return {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
   endfunction

   initial begin
      rst_n = 1'b0; clr_i = 1'b0; clr_ch_i = 4'd0; tu_en = 1'b0; valid_i = 1'b0;
      thr_hi_i = 16'd100; thr_lo_i = 16'd50; signal_i = 16'd0; ch_i = 2'd0;
      step(2);
      check("rst_tu", 64'(tu_since_o), 64'(tus(1000, 1000, 1000, 1000)));
      check("rst_active", 64'(active_o), 64'd0);
      check("rst_hit", 64'({hit_o, hit_ch_o}), 64'd0);
      check("rst_recent", 64'({recent_valid_o, recent_ch_o}), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      rst_n = 1'b1;
      step(1);

      // Idle time units: counts stay saturated
      tu_en = 1'b1;
      step(5);
      tu_en = 1'b0;
      step(1);
      check("idle_tu", 64'(tu_since_o), 64'(tus(1000, 1000, 1000, 1000)));
      check("idle_active", 64'(active_o), 64'd0);
      check("idle_rvalid", 64'(recent_valid_o), 64'd0);

      // Trigger ch2, then 3 time units
      sample(2'd2, 16'd200);
      step(1);
      check("trig2_hit", 64'(hit_o), 64'd1);
      check("trig2_hitch", 64'(hit_ch_o), 64'd2);
      check("trig2_active", 64'(active_o), 64'b0100);
      check("trig2_cnt", 64'(tu_since_o), 64'(tus(1000, 0, 1000, 1000)));
      valid_i = 1'b0; tu_en = 1'b1;
      step(1);
      check("trig2_pulse", 64'(hit_o), 64'd0);
      step(2);
      tu_en = 1'b0;
      step(1);
      check("trig2_cnt3", 64'(tu_since_o), 64'(tus(1000, 3, 1000, 1000)));
      check("trig2_recent", 64'(recent_ch_o), 64'd2);
      check("trig2_rvalid", 64'(recent_valid_o), 64'd1);

      // Hysteresis on ch1
      sample(2'd1, 16'd200);
      step(1);
      check("hys_trig", 64'(active_o), 64'b0110);
      sample(2'd1, 16'd75); tu_en = 1'b1;
      step(1);
      check("hys_hold", 64'(active_o), 64'b0110);
      check("hys_hold_cnt", 64'(tu_since_o), 64'(tus(1000, 4, 1, 1000)));
      sample(2'd1, 16'd40);
      step(1);
      check("hys_rel", 64'(active_o), 64'b0100);
      check("hys_rel_cnt", 64'(tu_since_o), 64'(tus(1000, 5, 2, 1000)));
      valid_i = 1'b0;
      step(1);
      check("hys_run", 64'(tu_since_o), 64'(tus(1000, 6, 3, 1000)));

      // Trigger beats increment; clear beats trigger
      sample(2'd0, 16'd200);
      step(1);
      check("tw_cnt", 64'(tu_since_o), 64'(tus(1000, 7, 4, 0)));
      check("tw_active", 64'(active_o), 64'b0101);
      check("tw_hitch", 64'({hit_o, hit_ch_o}), 64'b100);
      clr_ch_i = 4'b0001;
      step(1);
      check("clr_cnt", 64'(tu_since_o), 64'(tus(1000, 8, 5, 1000)));
      check("clr_active", 64'(active_o), 64'b0100);
      check("clr_nohit", 64'(hit_o), 64'd0);
      clr_ch_i = 4'd0; tu_en = 1'b0;

      // Tie between ch1 and ch3
      sample(2'd3, 16'd200);
      step(1);
      sample(2'd1, 16'd200);
      step(1);
      check("tie_cnt", 64'(tu_since_o), 64'(tus(0, 8, 0, 1000)));
      check("tie_active", 64'(active_o), 64'b1110);
      valid_i = 1'b0;
      step(1);
      check("tie_recent", 64'(recent_ch_o), 64'd1);

      // Saturation and timeout
      tu_en = 1'b1;
      step(999);
      check("sat_999", 64'(tu_since_o), 64'(tus(999, 1000, 999, 1000)));
      check("sat_999_act", 64'(active_o), 64'b1010);
      step(1);
      check("sat_1000", 64'(tu_since_o), 64'(tus(1000, 1000, 1000, 1000)));
      check("sat_timeout", 64'(active_o), 64'd0);
      step(1);
      check("sat_hold", 64'(tu_since_o), 64'(tus(1000, 1000, 1000, 1000)));
      check("sat_rvalid", 64'(recent_valid_o), 64'd0);
      tu_en = 1'b0;

      // Global clear with simultaneous time unit
      sample(2'd2, 16'd200);
      step(1);
      valid_i = 1'b0; clr_i = 1'b1; tu_en = 1'b1;
      step(1);
      check("gclr_cnt", 64'(tu_since_o), 64'(tus(1000, 1000, 1000, 1000)));
      check("gclr_active", 64'(active_o), 64'd0);
      clr_i = 1'b0; tu_en = 1'b0;

      // Out-of-range channel on the 3-channel instance
      sample(2'd1, 16'd200);
      step(1);
      check("b_trig", 64'(b_active_o), 64'b010);
      sample(2'd3, 16'd200);
      step(1);
      check("b_err", 64'(b_err_o), 64'd1);
      check("b_err_hit", 64'(b_hit_o), 64'd0);
      check("b_err_active", 64'(b_active_o), 64'b010);
      check("b_err_cnt", 64'(b_tu_since_o), 64'({10'd1000, 10'd0, 10'd1000}));
      valid_i = 1'b0;
      step(1);
      check("b_err_pulse", 64'(b_err_o), 64'd0);

      // Asynchronous reset mid-count
      tu_en = 1'b1;
      step(3);
      check("pre_rst_cnt", 64'(tu_since_o), 64'(tus(3, 1000, 3, 1000)));
      rst_n = 1'b0;
      #1;
      check("arst_tu", 64'(tu_since_o), 64'(tus(1000, 1000, 1000, 1000)));
      check("arst_active", 64'(active_o), 64'd0);
      check("arst_hit", 64'({hit_o, hit_ch_o}), 64'd0);
      check("arst_recent", 64'({recent_valid_o, recent_ch_o}), 64'd0);
      check("arst_err", 64'({err_o, b_err_o}), 64'd0);
      check("arst_b_active", 64'(b_active_o), 64'd0);
      tu_en = 1'b0;
      rst_n = 1'b1;
      step(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_threshold_tracker.md
# multi_threshold_tracker

Parametrised, multi-channel successor to the single-channel time-since-threshold tracker. It accepts time-multiplexed detector samples tagged with a channel index. For each channel it keeps a saturating count of time units since the signal last exceeded a high threshold, plus a hysteresis "active" flag. It also reports which channel crossed most recently, and sits between the per-channel magnitude detectors and the direction/bearing logic.

## Interface
- DW, 16: sample width (unsigned)
- NCH, 4: number of channels, ≥1
- MAX_TIME, 1000: counter saturation value in time units
- CW (localparam): max(1, $clog2(NCH))
- TW (localparam): $clog2(MAX_TIME+1), so MAX_TIME is representable

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clr_i  in  1  synchronous clear of all channels
- clr_ch_i  in  NCH  synchronous per-channel clear mask
- tu_en  in  1  time-unit strobe, one cycle per unit
- thr_hi_i  in  DW  trigger threshold, strict `>`
- thr_lo_i  in  DW  release threshold, strict `<`; software keeps thr_lo_i ≤ thr_hi_i
- signal_i  in  DW  sample
- ch_i  in  CW  sample channel index
- valid_i  in  1  sample qualifier
- tu_since_o  out  NCH×TW  per-channel time units since last trigger
- active_o  out  NCH  per-channel hysteresis flag
- hit_o  out  1  pulse: registered sample triggered
- hit_ch_o  out  CW  channel of hit_o
- recent_ch_o  out  CW  channel with smallest tu_since_o
- recent_valid_o  out  1  that channel's count is below MAX_TIME
- err_o  out  1  pulse: valid_i with ch_i ≥ NCH

## Operation
- Reset values:
  - tu_since_o: every lane = MAX_TIME
  - active_o = 0
  - hit_o = 0, hit_ch_o = 0
  - recent_ch_o = 0, recent_valid_o = 0
  - err_o = 0
- Clear behaviour:
  - clr_i forces reset values on all channel state.
  - clr_ch_i[k] does the same for channel k only.
  - Clears take priority over everything else in that cycle.
- Sample on channel k (valid_i, ch_i = k < NCH):
  - signal_i > thr_hi_i → count[k] ← 0, active[k] ← 1, hit_o pulses with hit_ch_o = k.
  - signal_i < thr_lo_i → active[k] ← 0.
  - Otherwise active[k] is held.
- Counting: on tu_en, every channel not triggered in that cycle increments, saturating at MAX_TIME. This includes the addressed channel when its sample does not trigger.
- Trigger wins over increment in the same cycle.
- Count reaching MAX_TIME forces active[k] ← 0 (timeout).
- Per-channel state is ARMED (active = 0) or TRIGGERED (active = 1):
  - ARMED → TRIGGERED on a trigger.
  - TRIGGERED → ARMED on a release sample, timeout, or clear.
  - A trigger in TRIGGERED re-zeroes the count.
- Out-of-range ch_i: sample ignored, err_o pulses, counting proceeds normally.
- Recent selection:
  - recent_ch_o is the arg-min of the counts; ties go to the lowest index.
  - recent_valid_o = (min < MAX_TIME).

## Timing
- Counts, active_o, hit_o, hit_ch_o and err_o update on the clock edge after the input cycle (1-cycle latency).
- hit_o and err_o are single-cycle pulses.
- recent_ch_o and recent_valid_o are registered from the registered counts: 2 cycles after the sample.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.
- tu_en may coincide with valid_i, clr_i, or both; the priority is clear > trigger > increment.
- rst_n assertion mid-operation immediately forces reset values; deassertion is synchronised externally.

## Structure
- Package threshold_pkg holds:
  - the trk_state_e enum {ARMED, TRIGGERED}
  - function sat_inc(count, max)
  - function argmin for the recent-channel reduction
- Sub-module threshold_channel, instantiated NCH times via generate. It holds one count plus its state, with inputs hit, release, tu_en and clr.
- The top level does channel decode, error detection, the registered arg-min reduction and hit/err pulse generation.

## Test plan
- Reset, then 5 tu_en strobes with no samples → all tu_since_o = 1000, active_o = 0, recent_valid_o = 0.
- thr_hi = 100, thr_lo = 50; sample 200 on ch 2, then 3 tu_en → tu_since[2] = 3, active_o = 4'b0100, hit_o pulses once with hit_ch_o = 2, recent_ch_o = 2.
- Hysteresis: trigger ch 1, then samples 75 (held, active stays 1), then 40 → active[1] = 0, count keeps running.
- Same-cycle trigger on ch 0 plus tu_en → count[0] = 0 while other non-saturated channels increment; same-cycle clr_ch_i[0] → count[0] = 1000.
- Saturation: trigger ch 3, then 1000 tu_en → count = 1000, active[3] = 0; a further tu_en leaves it at 1000. Tie between ch 1 and ch 3 both at 0 → recent_ch_o = 1.
- With NCH = 3: sample with ch_i = 3 → err_o pulses and no channel state changes; rst_n pulsed mid-count → all outputs return to their reset values immediately.
